// File: rtl/vpu_scoreboard_pkg.sv
// Shared types and constants for the cosim vector scoreboard blocks.
package vpu_scoreboard_pkg;
  localparam int N_LANES   = 8;
  localparam int N_BANKS   = 5;
  localparam int BANK_SIZE = 80;
  localparam int VRF_DATA  = 64;
  localparam int MAX_VLEN  = 4096;
  localparam int N_VREGS   = 32;

  localparam int ROWS_PER_VREG = MAX_VLEN / 64 / N_LANES;
  localparam int VL_W    = $clog2(MAX_VLEN / 8) + 1;
  localparam int BLK_W   = $clog2(MAX_VLEN / 64);
  localparam int NBLK_W  = BLK_W + 1;
  localparam int BYTES_W = VL_W + 3;
  localparam int LANE_W  = $clog2(N_LANES);
  localparam int BANK_W  = $clog2(N_BANKS);
  localparam int ADDR_W  = $clog2(BANK_SIZE);
  localparam int VREG_W  = $clog2(N_VREGS);

  typedef enum logic [1:0] {SEW8, SEW16, SEW32, SEW64} sew_e;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, DRAIN} rdseq_state_e;

  typedef struct packed {
    logic [VREG_W-1:0] vreg;
    logic [VL_W-1:0]   vl;
    sew_e              sew;
  } rdseq_req_t;

  // Number of 64-bit blocks covering vl elements of 2^sew bytes each.
  function automatic logic [NBLK_W-1:0] blk_count(input logic [VL_W-1:0] vl, input sew_e sew);
    logic [BYTES_W-1:0] nbytes;
    nbytes = BYTES_W'(vl) << sew;
    return NBLK_W'((nbytes + BYTES_W'(7)) >> 3);
  endfunction
endpackage

// File: rtl/vpu_vreg_addr_gen.sv
// Block counter for one vreg readout plus lane/bank/row address of the current block.
module vpu_vreg_addr_gen
  import vpu_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [VREG_W-1:0] vreg,
  input  logic [NBLK_W-1:0] nblk,
  output logic [BLK_W-1:0]  blk,
  output logic [LANE_W-1:0] lane,
  output logic [BANK_W-1:0] bank,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [NBLK_W-1:0] nblk_q;
  logic [ADDR_W-1:0] base_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk    <= '0;
      nblk_q <= '0;
      bank   <= '0;
      base_q <= '0;
    end else if (load) begin
      blk    <= '0;
      nblk_q <= nblk;
      bank   <= BANK_W'(int'(vreg) % N_BANKS);
      base_q <= ADDR_W'(int'(vreg) / N_BANKS * ROWS_PER_VREG);
    end else if (inc) begin
      blk <= blk + BLK_W'(1);
    end
  end

  // Blocks stripe across lanes first, then advance one row per lane sweep.
  assign lane = LANE_W'(int'(blk) % N_LANES);
  assign addr = base_q + ADDR_W'(int'(blk) / N_LANES);
  assign last = (NBLK_W'(blk) + NBLK_W'(1)) == nblk_q;
endmodule

// File: rtl/vpu_vreg_readout_seq.sv
// Streams one vector register out of the VRF debug port as 64-bit blocks.
// Define VPU_SB_RDSEQ_BOUNDS_CHK_EN to reject out-of-range requests instead of clamping vl.
module vpu_vreg_readout_seq
  import vpu_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [VREG_W-1:0]   req_vreg,
  input  logic [VL_W-1:0]     req_vl,
  input  logic [1:0]          req_sew,
  input  logic                flush,
  output logic                rd_valid,
  input  logic                rd_gnt,
  output logic [LANE_W-1:0]   rd_lane,
  output logic [BANK_W-1:0]   rd_bank,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rsp_valid,
  input  logic [VRF_DATA-1:0] rsp_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [VRF_DATA-1:0] out_data,
  output logic [BLK_W-1:0]    out_blk,
  output logic [7:0]          out_bmask,
  output logic                out_last,
  output logic                err
);
  rdseq_state_e      state, state_nxt;
  rdseq_req_t        req;
  logic [VL_W-1:0]   vl_max, vl_eff;
  logic [BYTES_W-1:0] bytes_in;
  logic [NBLK_W-1:0] nblk_in;
  logic [2:0]        tail_in, tail_q;
  logic              bad_req, load, inc, cap, err_nxt, last;

  assign req = '{vreg: req_vreg, vl: req_vl, sew: sew_e'(req_sew)};

  always_comb begin
    vl_max   = VL_W'(MAX_VLEN / 8) >> req.sew;
    vl_eff   = (req.vl > vl_max) ? vl_max : req.vl;
    bytes_in = BYTES_W'(vl_eff) << req.sew;
    tail_in  = bytes_in[2:0];
    nblk_in  = blk_count(vl_eff, req.sew);
    bad_req  = (nblk_in == '0);
`ifdef VPU_SB_RDSEQ_BOUNDS_CHK_EN
    bad_req = bad_req || (req.vl > vl_max) || (int'(req.vreg) >= N_VREGS) ||
              (int'(req.vreg) / N_BANKS * ROWS_PER_VREG + (int'(nblk_in) - 1) / N_LANES >= BANK_SIZE);
`endif
  end

  vpu_vreg_addr_gen u_addr_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .inc  (inc),
    .vreg (req.vreg),
    .nblk (nblk_in),
    .blk  (out_blk),
    .lane (rd_lane),
    .bank (rd_bank),
    .addr (rd_addr),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tail_q   <= '0;
      out_data <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= err_nxt;
      if (load) tail_q   <= tail_in;
      if (cap)  out_data <= rsp_data;
    end
  end

  // A granted read always has one response coming; DRAIN swallows it after a flush.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    inc       = 1'b0;
    cap       = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE:
        if (req_valid && !flush) begin
          if (bad_req) err_nxt = 1'b1;
          else begin
            load      = 1'b1;
            state_nxt = ISSUE;
          end
        end
      ISSUE:
        if (flush)       state_nxt = rd_gnt ? DRAIN : IDLE;
        else if (rd_gnt) state_nxt = WAIT;
      WAIT:
        if (flush) state_nxt = rsp_valid ? IDLE : DRAIN;
        else if (rsp_valid) begin
          cap       = 1'b1;
          state_nxt = EMIT;
        end
      EMIT:
        if (flush) state_nxt = IDLE;
        else if (out_ready) begin
          if (last) state_nxt = IDLE;
          else begin
            inc       = 1'b1;
            state_nxt = ISSUE;
          end
        end
      DRAIN:
        if (rsp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rd_valid  = (state == ISSUE);
  assign out_valid = (state == EMIT);
  assign out_last  = out_valid && last;
  assign out_bmask = !out_valid ? 8'h00 :
                     (last && tail_q != '0) ? ((8'd1 << tail_q) - 8'd1) : 8'hFF;
endmodule

// File: tb/tb_vpu_vreg_readout_seq.sv
// Directed, table-driven bench for vpu_vreg_readout_seq with hand-written flush/reset sequences.
`timescale 1ns/1ps
module tb_vpu_vreg_readout_seq;
  import vpu_scoreboard_pkg::*;

  logic                clk = 1'b0, rst_n = 1'b0;
  logic                req_valid = 1'b0, flush = 1'b0, rd_gnt = 1'b0, rsp_valid = 1'b0, out_ready = 1'b0;
  logic [VREG_W-1:0]   req_vreg = '0;
  logic [VL_W-1:0]     req_vl = '0;
  logic [1:0]          req_sew = '0;
  logic [VRF_DATA-1:0] rsp_data = '0;
  logic                req_ready, rd_valid, out_valid, out_last, err;
  logic [LANE_W-1:0]   rd_lane;
  logic [BANK_W-1:0]   rd_bank;
  logic [ADDR_W-1:0]   rd_addr;
  logic [VRF_DATA-1:0] out_data;
  logic [BLK_W-1:0]    out_blk;
  logic [7:0]          out_bmask;

  vpu_vreg_readout_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_vreg(req_vreg), .req_vl(req_vl), .req_sew(req_sew), .flush(flush),
    .rd_valid(rd_valid), .rd_gnt(rd_gnt), .rd_lane(rd_lane), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_blk(out_blk), .out_bmask(out_bmask), .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       vreg;
    int       vl;
    int       sew;
    int       nblk;
    logic [7:0] last_mask;
    bit       err;
    int       gnt_dly;
    int       rdy_dly;
  } vec_t;

  vec_t tv[9];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mkdata(input int v, input int b);
    logic [31:0] bb;
    bb = 32'(b);
    return {16'hC0DE, v[7:0], b[7:0], 32'h1234_5678 ^ (bb * 32'h0101_0101)};
  endfunction

  task automatic start(input int vreg, input int vl, input int sew);
    @(negedge clk);
    req_valid = 1'b1;
    req_vreg  = VREG_W'(vreg);
    req_vl    = VL_W'(vl);
    req_sew   = 2'(sew);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run(input vec_t v);
    logic [LANE_W-1:0] el;
    logic [BANK_W-1:0] eb;
    logic [ADDR_W-1:0] ea;
    logic [63:0]       ed;
    @(negedge clk);
    chk("req_ready idle", req_ready, 1);
    start(v.vreg, v.vl, v.sew);
    if (v.err) begin
      chk("err pulse", err, 1);
      chk("err no rd", rd_valid, 0);
      chk("err ready", req_ready, 1);
      @(negedge clk);
      chk("err one cycle", err, 0);
      chk("err no rd later", rd_valid, 0);
      chk("err ready later", req_ready, 1);
      return;
    end
    chk("no err", err, 0);
    for (int b = 0; b < v.nblk; b++) begin
      el = LANE_W'(b % 8);
      eb = BANK_W'(v.vreg % 5);
      ea = ADDR_W'(v.vreg / 5 * 8 + b / 8);
      ed = mkdata(v.vreg, b);
      chk("rd_valid", rd_valid, 1);
      chk("rd addr", {rd_lane, rd_bank, rd_addr}, {el, eb, ea});
      for (int d = 0; d < v.gnt_dly; d++) begin
        @(negedge clk);
        chk("rd hold valid", rd_valid, 1);
        chk("rd hold addr", {rd_lane, rd_bank, rd_addr}, {el, eb, ea});
      end
      rd_gnt = 1'b1;
      @(negedge clk);
      rd_gnt = 1'b0;
      chk("single read", rd_valid, 0);
      chk("no early out", out_valid, 0);
      rsp_valid = 1'b1;
      rsp_data  = ed;
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_data  = ~ed;
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, ed);
      chk("out_blk", out_blk, b);
      chk("out_bmask", out_bmask, (b == v.nblk - 1) ? v.last_mask : 8'hFF);
      chk("out_last", out_last, b == v.nblk - 1);
      for (int d = 0; d < v.rdy_dly; d++) begin
        @(negedge clk);
        chk("out hold valid", out_valid, 1);
        chk("out hold data", out_data, ed);
        chk("out hold no rd", rd_valid, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("done idle", req_ready, 1);
    chk("done no out", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = '{7, 16, 3, 16, 8'hFF, 0, 0, 0};
    tv[1] = '{0, 13, 0, 2, 8'h1F, 0, 0, 0};
    tv[2] = '{3, 0, 0, 0, 8'h00, 1, 0, 0};
    tv[3] = '{31, 3, 2, 2, 8'h0F, 0, 0, 0};
    tv[4] = '{12, 1, 1, 1, 8'h03, 0, 0, 0};
`ifdef VPU_SB_RDSEQ_BOUNDS_CHK_EN
    tv[5] = '{20, 65, 3, 0, 8'h00, 1, 0, 0};
    tv[7] = '{5, 600, 0, 0, 8'h00, 1, 0, 0};
`else
    tv[5] = '{20, 65, 3, 64, 8'hFF, 0, 0, 0};
    tv[7] = '{5, 600, 0, 64, 8'hFF, 0, 0, 0};
`endif
    tv[6] = '{9, 2, 3, 2, 8'hFF, 0, 5, 4};
    tv[8] = '{26, 9, 2, 5, 8'h0F, 0, 1, 1};

    #1;
    chk("rst req_ready", req_ready, 1);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst err", err, 0);
    chk("rst out_bmask", out_bmask, 0);
    chk("rst out_last", out_last, 0);
    chk("rst out_data", out_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run(tv[i]);

    // Flush in WAIT; the response turns up three cycles later.
    start(1, 4, 3);
    rd_gnt = 1'b1;
    @(negedge clk);
    rd_gnt = 1'b0;
    flush  = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("drain busy", req_ready, 0);
    chk("drain no out", out_valid, 0);
    @(negedge clk);
    chk("drain busy 2", req_ready, 0);
    chk("drain no out 2", out_valid, 0);
    rsp_valid = 1'b1;
    rsp_data  = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("drain done ready", req_ready, 1);
    chk("drain done no out", out_valid, 0);
    chk("drain done no rd", rd_valid, 0);
    @(negedge clk);
    chk("drain after no out", out_valid, 0);

    // Flush in EMIT wins over a simultaneous out_ready.
    start(2, 8, 3);
    rd_gnt = 1'b1;
    @(negedge clk);
    rd_gnt    = 1'b0;
    rsp_valid = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("emit before flush", out_valid, 1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("emit flush out", out_valid, 0);
    chk("emit flush ready", req_ready, 1);
    chk("emit flush no rd", rd_valid, 0);

    // Flush in ISSUE before grant, then a stray response in IDLE.
    start(3, 8, 3);
    chk("issue before flush", rd_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("issue flush no rd", rd_valid, 0);
    chk("issue flush ready", req_ready, 1);
    rsp_valid = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("stray rsp no out", out_valid, 0);
    chk("stray rsp ready", req_ready, 1);

    // Flush with a same-cycle grant must still drain the response.
    start(4, 8, 3);
    flush  = 1'b1;
    rd_gnt = 1'b1;
    @(negedge clk);
    flush  = 1'b0;
    rd_gnt = 1'b0;
    chk("gnt flush drain", req_ready, 0);
    chk("gnt flush no rd", rd_valid, 0);
    rsp_valid = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("gnt flush ready", req_ready, 1);
    chk("gnt flush no out", out_valid, 0);

    // Async reset while a read is outstanding.
    start(5, 8, 3);
    rd_gnt = 1'b1;
    @(negedge clk);
    rd_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ready", req_ready, 1);
    chk("async rst no rd", rd_valid, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_valid = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("post rst rsp no out", out_valid, 0);
    chk("post rst ready", req_ready, 1);
    run(tv[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
